// File: rtl/pattern_pkg.sv
// Pattern generator shared types: mode encoding, colour palette, parameter defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pattern_pkg;

  localparam int HACTIVE_DEF    = 800;
  localparam int VACTIVE_DEF    = 600;
  localparam int NBARS_DEF      = 6;
  localparam int SCROLL_DIV_DEF = 4;

  typedef enum logic [1:0] {
    MODE_HBARS   = 2'd0,
    MODE_VBARS   = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BLACK   = 2'd3
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [2:0] IDX_WHITE = 3'd6;
  localparam logic [2:0] IDX_BLACK = 3'd7;

  // red, green, blue, yellow, magenta, cyan, white, black
  localparam rgb_t PALETTE [0:7] = '{
    '{8'hFF, 8'h00, 8'h00},
    '{8'h00, 8'hFF, 8'h00},
    '{8'h00, 8'h00, 8'hFF},
    '{8'hFF, 8'hFF, 8'h00},
    '{8'hFF, 8'h00, 8'hFF},
    '{8'h00, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'hFF},
    '{8'h00, 8'h00, 8'h00}
  };

endpackage

// File: rtl/pattern_gen_bar_index.sv
// Maps a coordinate in [0,SPAN) to floor(coord*NBARS/SPAN) using constant thresholds.
// Latency: combinational.
// Backpressure: none.
// Ports: coord (12-bit unsigned, caller guarantees < SPAN when result is used), idx (3-bit).
module bar_index #(
  parameter int SPAN  = 800,
  parameter int NBARS = 6
) (
  input  logic [11:0] coord,
  output logic [2:0]  idx
);

  // Bar k starts at ceil(k*SPAN/NBARS); thresholds are elaboration-time
  // constants and ascending, so the last one passed wins.
  always_comb begin
    idx = 3'd0;
    for (int k = 1; k < NBARS; k++) begin
      if (int'(coord) >= (k * SPAN + NBARS - 1) / NBARS) begin
        idx = 3'(k);
      end
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Test-pattern generator: colour bars (optionally scrolling), checkerboard or black per pixel.
// Latency: 1 cycle from spotX/spotY/mode to bck_r/g/b.
// Backpressure: none; one pixel accepted and produced every cycle.
// Ports: clk, reset (sync active-high), spotX/spotY (11-bit signed pixel position),
//        mode (2-bit pattern select, sampled at frame start), bck_r/g/b (8-bit registered colour).
// Build option: define PATTERN_SCROLL_EN to enable bar scrolling (frame counter + offset).
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int HACTIVE    = HACTIVE_DEF,
  parameter int VACTIVE    = VACTIVE_DEF,
  parameter int NBARS      = NBARS_DEF,
  parameter int SCROLL_DIV = SCROLL_DIV_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [10:0] spotX,
  input  logic signed [10:0] spotY,
  input  logic [1:0]         mode,
  output logic [7:0]         bck_r,
  output logic [7:0]         bck_g,
  output logic [7:0]         bck_b
);

  mode_e       mode_in;
  mode_e       mode_q;
  mode_e       mode_cur;
  logic        frame_start;
  logic        in_active;
  logic [10:0] offset_eff;
  logic [11:0] x_raw, y_raw;
  logic [11:0] x_sum, y_sum;
  logic [11:0] x_eff, y_eff;
  logic [11:0] x_coord, y_coord;
  logic [2:0]  x_idx, y_idx;
  rgb_t        pix;

  assign mode_in     = mode_e'(mode);
  assign frame_start = (spotX == 11'sd0) && (spotY == 11'sd0);
  // The first pixel of a frame is already rendered in the newly sampled mode.
  assign mode_cur    = frame_start ? mode_in : mode_q;

  assign in_active = (spotX >= 11'sd0) && (int'(spotX) < HACTIVE) &&
                     (spotY >= 11'sd0) && (int'(spotY) < VACTIVE);

`ifdef PATTERN_SCROLL_EN
  localparam int FCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [FCW-1:0] frame_cnt, frame_cnt_nxt;
  logic [10:0]    offset, offset_nxt;

  always_comb begin
    frame_cnt_nxt = frame_cnt;
    offset_nxt    = offset;
    if (frame_start) begin
      if (mode_in != mode_q) begin
        // New pattern always starts unscrolled.
        frame_cnt_nxt = '0;
        offset_nxt    = '0;
      end else if (frame_cnt == FCW'(SCROLL_DIV - 1)) begin
        frame_cnt_nxt = '0;
        case (mode_q)
          MODE_HBARS: offset_nxt = (offset == 11'(VACTIVE - 1)) ? 11'd0 : offset + 11'd1;
          MODE_VBARS: offset_nxt = (offset == 11'(HACTIVE - 1)) ? 11'd0 : offset + 11'd1;
          default:    offset_nxt = offset;
        endcase
      end else begin
        frame_cnt_nxt = frame_cnt + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      offset    <= '0;
    end else begin
      frame_cnt <= frame_cnt_nxt;
      offset    <= offset_nxt;
    end
  end

  // Use the updated value so the whole frame, including its first pixel,
  // shares one scroll position.
  assign offset_eff = offset_nxt;
`else
  assign offset_eff = 11'd0;
`endif

  // Only meaningful inside the active area, where positions are non-negative.
  assign x_raw = {1'b0, spotX};
  assign y_raw = {1'b0, spotY};
  assign x_sum = x_raw + {1'b0, offset_eff};
  assign y_sum = y_raw + {1'b0, offset_eff};
  // Sum stays below 2*span, so a single conditional subtract is a full modulo.
  assign x_eff = (x_sum >= 12'(HACTIVE)) ? x_sum - 12'(HACTIVE) : x_sum;
  assign y_eff = (y_sum >= 12'(VACTIVE)) ? y_sum - 12'(VACTIVE) : y_sum;

  // One mapper per axis; the checkerboard uses unscrolled positions.
  assign x_coord = (mode_cur == MODE_VBARS) ? x_eff : x_raw;
  assign y_coord = (mode_cur == MODE_HBARS) ? y_eff : y_raw;

  bar_index #(.SPAN(HACTIVE), .NBARS(NBARS)) u_x_index (
    .coord (x_coord),
    .idx   (x_idx)
  );

  bar_index #(.SPAN(VACTIVE), .NBARS(NBARS)) u_y_index (
    .coord (y_coord),
    .idx   (y_idx)
  );

  always_comb begin
    pix = '0;
    if (in_active) begin
      case (mode_cur)
        MODE_HBARS:   pix = PALETTE[y_idx];
        MODE_VBARS:   pix = PALETTE[x_idx];
        // Parity of the two cell numbers is just the XOR of their LSBs.
        MODE_CHECKER: pix = (x_idx[0] ^ y_idx[0]) ? PALETTE[IDX_BLACK] : PALETTE[IDX_WHITE];
        default:      pix = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bck_r  <= 8'd0;
      bck_g  <= 8'd0;
      bck_b  <= 8'd0;
      mode_q <= MODE_HBARS;
    end else begin
      bck_r <= pix.r;
      bck_g <= pix.g;
      bck_b <= pix.b;
      if (frame_start) begin
        mode_q <= mode_in;
      end
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Randomised and directed check of pattern_gen against an arithmetic reference model.
// Latency: inputs applied after a falling edge, outputs sampled at the next falling edge.
// Backpressure: none.
module tb_pattern_gen;

  localparam int H  = 800;
  localparam int V  = 600;
  localparam int NB = 6;
  localparam int SD = 4;

  localparam logic [23:0] RED    = 24'hFF0000;
  localparam logic [23:0] GREEN  = 24'h00FF00;
  localparam logic [23:0] YELLOW = 24'hFFFF00;
  localparam logic [23:0] CYAN   = 24'h00FFFF;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;
  localparam logic [23:0] BLACK  = 24'h000000;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [10:0] spotX;
  logic signed [10:0] spotY;
  logic [1:0]         mode;
  logic [7:0]         bck_r, bck_g, bck_b;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_mode = 0;
  int m_off  = 0;
  int m_fc   = 0;

  always #5 clk = ~clk;

  pattern_gen #(
    .HACTIVE    (H),
    .VACTIVE    (V),
    .NBARS      (NB),
    .SCROLL_DIV (SD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .spotX (spotX),
    .spotY (spotY),
    .mode  (mode),
    .bck_r (bck_r),
    .bck_g (bck_g),
    .bck_b (bck_b)
  );

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pal(input int i);
    case (i)
      0:       return RED;
      1:       return GREEN;
      2:       return 24'h0000FF;
      3:       return YELLOW;
      4:       return 24'hFF00FF;
      5:       return CYAN;
      6:       return WHITE;
      default: return BLACK;
    endcase
  endfunction

  function automatic logic [23:0] model_pix(input int x, input int y, input int m, input int off);
    if (x < 0 || x >= H || y < 0 || y >= V) return BLACK;
    case (m)
      0:       return pal(((y + off) % V) * NB / V);
      1:       return pal(((x + off) % H) * NB / H);
      2:       return ((((x * NB / H) ^ (y * NB / V)) & 1) != 0) ? BLACK : WHITE;
      default: return BLACK;
    endcase
  endfunction

  // Apply one pixel, advance the model, and check the registered result.
  task automatic step(input string tag, input int x, input int y, input int m, input bit rst,
                      output logic [23:0] obs);
    logic [23:0] exp;
    reset = rst;
    spotX = 11'(x);
    spotY = 11'(y);
    mode  = 2'(m);
    if (rst) begin
      m_mode = 0;
      m_off  = 0;
      m_fc   = 0;
      exp    = BLACK;
    end else begin
      if (x == 0 && y == 0) begin
`ifdef PATTERN_SCROLL_EN
        if (m != m_mode) begin
          m_off = 0;
          m_fc  = 0;
        end else begin
          m_fc = (m_fc + 1) % SD;
          if (m_fc == 0) begin
            if (m_mode == 0) m_off = (m_off + 1) % V;
            else if (m_mode == 1) m_off = (m_off + 1) % H;
          end
        end
`endif
        m_mode = m;
      end
      exp = model_pix(x, y, m_mode, m_off);
    end
    @(negedge clk);
    obs = {bck_r, bck_g, bck_b};
    chk(tag, obs, exp);
  endtask

  initial begin
    logic [23:0] o;
    int cur_mode;
    int x, y, m;

    // reset
    step("rst0", 100, 100, 0, 1'b1, o);
    step("rst1", 0, 0, 2, 1'b1, o);
    chk("rst_black", o, BLACK);

    // horizontal bars, no frame start yet
    step("hb", 10, 0, 0, 1'b0, o);   chk("hb_y0", o, RED);
    step("hb", 10, 99, 0, 1'b0, o);  chk("hb_y99", o, RED);
    step("hb", 10, 100, 0, 1'b0, o); chk("hb_y100", o, GREEN);
    step("hb", 10, 599, 0, 1'b0, o); chk("hb_y599", o, CYAN);
    step("hb", 10, 600, 0, 1'b0, o); chk("hb_y600", o, BLACK);
    step("hb", -1, 50, 0, 1'b0, o);  chk("hb_xneg", o, BLACK);

    // vertical bars
    step("vb_fs", 0, 0, 1, 1'b0, o); chk("vb_x0", o, RED);
    step("vb", 133, 5, 1, 1'b0, o);  chk("vb_x133", o, RED);
    step("vb", 134, 5, 1, 1'b0, o);  chk("vb_x134", o, GREEN);
    step("vb", 800, 5, 1, 1'b0, o);  chk("vb_x800", o, BLACK);

    // checkerboard
    step("ck_fs", 0, 0, 2, 1'b0, o); chk("ck_00", o, WHITE);
    step("ck", 134, 0, 2, 1'b0, o);  chk("ck_134_0", o, BLACK);
    step("ck", 134, 100, 2, 1'b0, o); chk("ck_134_100", o, WHITE);

    // mid-frame mode change is deferred to the next frame start
    step("mc_fs", 0, 0, 0, 1'b0, o);  chk("mc_fs0", o, RED);
    step("mc", 10, 300, 1, 1'b0, o);  chk("mc_hold_a", o, YELLOW);
    step("mc", 140, 300, 1, 1'b0, o); chk("mc_hold_b", o, YELLOW);
    step("mc_fs", 0, 0, 1, 1'b0, o);  chk("mc_fs1", o, RED);
    step("mc", 140, 300, 1, 1'b0, o); chk("mc_vert", o, GREEN);

    // mode 3
    step("sb_fs", 0, 0, 3, 1'b0, o); chk("sb_00", o, BLACK);
    step("sb", 400, 300, 3, 1'b0, o); chk("sb_mid", o, BLACK);

    // randomised run, mid-frame mode noise and occasional frame starts
    cur_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 7) == 0) cur_mode = int'($urandom_range(0, 3));
        step("rand_fs", 0, 0, cur_mode, 1'b0, o);
      end else begin
        x = int'($urandom_range(0, 870)) - 30;
        y = int'($urandom_range(0, 670)) - 30;
        m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : cur_mode;
        step("rand", x, y, m, 1'b0, o);
      end
    end

`ifdef PATTERN_SCROLL_EN
    // scrolling: one step per SD frame starts, wraps after V steps
    step("sc_rst", 5, 5, 0, 1'b1, o);
    for (int i = 0; i < 4; i++) step("sc_fs", 0, 0, 0, 1'b0, o);
    step("sc", 5, 99, 0, 1'b0, o);  chk("sc_off1_y99", o, GREEN);
    for (int i = 0; i < 4 * V - 4; i++) step("sc_fs", 0, 0, 0, 1'b0, o);
    step("sc", 5, 99, 0, 1'b0, o);  chk("sc_wrap_y99", o, RED);
    step("sc", 5, 100, 0, 1'b0, o); chk("sc_wrap_y100", o, GREEN);

    // reset mid-frame with offset 37
    step("rs_rst", 5, 5, 0, 1'b1, o);
    for (int i = 0; i < 4 * 37; i++) step("rs_fs", 0, 0, 0, 1'b0, o);
    step("rs", 5, 99, 0, 1'b0, o);  chk("rs_off37", o, GREEN);
    step("rs", 5, 300, 0, 1'b0, o);
    step("rs_rst", 5, 300, 0, 1'b1, o); chk("rs_black", o, BLACK);
    step("rs", 5, 99, 0, 1'b0, o);  chk("rs_off0", o, RED);
    for (int i = 0; i < 3; i++) step("rs_fs", 0, 0, 0, 1'b0, o);
    step("rs", 5, 99, 0, 1'b0, o);  chk("rs_fc3", o, RED);
    step("rs_fs", 0, 0, 0, 1'b0, o);
    step("rs", 5, 99, 0, 1'b0, o);  chk("rs_fc_wrap", o, GREEN);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter HACTIVE, default 800, active pixels per line.
REQ-002 Parameter VACTIVE, default 600, active lines per frame.
REQ-003 Parameter NBARS, default 6, legal 1..8, number of bars/checker cells per axis.
REQ-004 Parameter SCROLL_DIV, default 4, legal 1..255, frames per one-pixel scroll step.
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 spotX  input  11 signed  current pixel column.
REQ-008 spotY  input  11 signed  current pixel line.
REQ-009 mode  input  2  pattern select: 0 horizontal bars, 1 vertical bars, 2 checkerboard, 3 solid black.
REQ-010 bck_r, bck_g, bck_b  output  8 each  registered pixel colour.

Function
REQ-011 Outputs SHALL be registered with exactly 1 cycle latency from spotX/spotY.
REQ-012 Pixel outside active area (spotX<0, spotX>=HACTIVE, spotY<0, spotY>=VACTIVE) SHALL produce {0,0,0}.
REQ-013 Palette index i SHALL map to: 0 red, 1 green, 2 blue, 3 yellow, 4 magenta, 5 cyan, 6 white, 7 black; each set channel = 255, others 0.
REQ-014 Mode 0: index = floor(Yeff*NBARS/VACTIVE), with Yeff = spotY + offset, minus VACTIVE if >= VACTIVE.
REQ-015 Mode 1: index = floor(Xeff*NBARS/HACTIVE), Xeff = spotX + offset, minus HACTIVE if >= HACTIVE.
REQ-016 Mode 2: cell parity = floor(spotX*NBARS/HACTIVE) XOR floor(spotY*NBARS/VACTIVE); parity 0 white, 1 black; not scrolled.
REQ-017 Mode 3: {0,0,0} for every pixel.
REQ-018 Index computation SHALL use compile-time constant thresholds only; no runtime divider or multiplier.
REQ-019 Frame start = cycle with spotX==0 and spotY==0.
REQ-020 Internal mode_q SHALL load mode only at frame start; pixel (0,0) SHALL already use the newly loaded mode; mode changes mid-frame SHALL be ignored until next frame start.
REQ-021 Frame counter 0..SCROLL_DIV-1 SHALL increment at each frame start, wrapping to 0.
REQ-022 At a frame start where frame counter wraps, offset SHALL increment by 1, wrapping to 0 after VACTIVE-1 (mode_q 0) or HACTIVE-1 (mode_q 1).
REQ-023 When frame start loads a mode different from mode_q, offset and frame counter SHALL clear to 0 instead of advancing.
REQ-024 Offset SHALL hold in modes 2 and 3.

Reset
REQ-025 With reset high at a rising edge: bck_r/g/b=0, mode_q=0, offset=0, frame counter=0, next cycle.
REQ-026 Reset mid-frame SHALL abort scroll state; first frame start after release reloads mode normally.

Configuration
REQ-027 Macro PATTERN_SCROLL_EN defined: frame counter and offset present, behaviour per REQ-021..024.
REQ-028 PATTERN_SCROLL_EN undefined: frame counter and offset absent, offset treated as constant 0; all other behaviour unchanged.

Structure
REQ-029 Package pattern_pkg SHALL hold the mode enum, the 8-entry palette constant and parameter defaults.
REQ-030 Sub-module bar_index SHALL map a coordinate to a 3-bit index given span and NBARS parameters; instantiated per axis.

Verification
REQ-031 Defaults, mode 0, no scroll: spotY 0, 99, 100, 599 -> red, red, green, cyan; one cycle after input.
REQ-032 Mode 1: spotX 133 -> red, 134 -> green (800*1/6 threshold 133.33); spotX 800 -> black.
REQ-033 Mode 2: (0,0) white, (134,0) black, (134,100) white.
REQ-034 mode changed 0->1 at line 300 -> output stays horizontal bars until next (0,0), then vertical bars.
REQ-035 PATTERN_SCROLL_EN, SCROLL_DIV 4, mode 0: after 4 frame starts offset=1, spotY 99 -> green; after 2400 steps offset wraps to 0.
REQ-036 reset asserted mid-frame with scroll offset 37 -> outputs 0 next cycle, offset 0, frame counter 0.
